led_breathe: RTL and testbench
==============================

// Module: led_breathe
// PURPOSE
//  Downstream consumer of the clock divider. Takes the divider's slow square wave (tick_in) and
//  turns each rising edge into a one-cycle tick. The ticks step a ramp-up/hold/ramp-down duty
//  sequencer that drives a PWM LED output ("breathing" LED).
//  Sits between the divider output and the board LED pin. Same clock domain as the divider.
// PARAMETERS
//  PWM_BITS    8   width of the PWM counter and duty; MAXD = 2**PWM_BITS-1
//  STEP        1   duty increment/decrement per tick; 1..MAXD
//  HOLD_TICKS  16  ticks spent in each hold state; 0 = hold states skipped
// PORTS
//  clk     in   1         system clock; single clock domain
//  rst     in   1         synchronous, active-high reset
//  tick_in in   1         divider output level, synchronous to clk
//  enable  in   1         0 = sequencer frozen, led forced low
//  led     out  1         registered PWM output
//  duty    out  PWM_BITS  current target duty
//  phase   out  2         state: 0=UP 1=HOLD_HI 2=DOWN 3=HOLD_LO
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Reset values: led=0, duty=0, phase=UP, hold_cnt=0, pwm_cnt=0, duty_act=0.
//  Edge detect:
//   - tick = tick_in & ~tick_prev. During rst, tick_prev <= tick_in, so a tick_in held high
//     across reset release produces no tick.
//   - A long high level gives exactly one tick.
//  PWM:
//   - pwm_cnt is free-running. It wraps MAXD->0 and never pauses, even when enable=0.
//   - duty_act <= duty only on the cycle pwm_cnt==MAXD, so there are no mid-period glitches.
//     If a tick lands on the same cycle, the pre-tick duty is loaded.
//   - led <= enable & (pwm_cnt < duty_act). Latency is 1 clk from pwm_cnt.
//   - duty_act==0 -> led always 0. Full-on is impossible: max high time is MAXD of 2**PWM_BITS cycles.
//  FSM: advances only on a cycle with tick & enable. Otherwise all state holds and the tick is dropped.
//   - UP: if duty+STEP >= MAXD then duty=MAXD and go to HOLD_HI (to DOWN if HOLD_TICKS==0),
//     else duty += STEP. Compute with PWM_BITS+1 bits, no wrap.
//   - HOLD_HI: hold_cnt++. When hold_cnt==HOLD_TICKS-1, clear hold_cnt and go to DOWN.
//   - DOWN: if duty <= STEP then duty=0 and go to HOLD_LO (to UP if HOLD_TICKS==0),
//     else duty -= STEP. No underflow.
//   - HOLD_LO: same counting as HOLD_HI, then go to UP.
//  Other rules:
//   - enable=0: FSM, duty and hold_cnt frozen; led=0 on the next clk.
//     Raising enable resumes exactly where it stopped.
//   - rst mid-operation: all reset values on the following edge. Pending hold progress is discarded.
// STRUCTURE
//  - Shared package/header led_breathe_pkg: phase encodings (PH_UP, PH_HOLD_HI, PH_DOWN,
//    PH_HOLD_LO) and the 2-bit phase width.
//  - One sub-module, tick_edge (clk, rst, level_in -> pulse_out), holding the edge detector
//    with the reset-suppression rule above. The FSM, PWM counter and output register stay in
//    led_breathe.
//  - hold_cnt width: $clog2(HOLD_TICKS+1), minimum 1.
// TESTING (PWM_BITS=4, STEP=4, HOLD_TICKS=2, enable=1 unless noted)
//  1. tick_in=1 through reset and after release -> led=0, duty=0, phase=0; no tick; duty stays 0.
//  2. 4 tick_in rising edges -> duty 4,8,12,15 (saturated), then phase=1.
//     A 20-cycle-wide high pulse counts as one tick.
//  3. From step 2, 2 ticks -> phase=2; 4 ticks -> duty 11,7,3,0, phase=3;
//     2 ticks -> phase=0; next tick -> duty=4.
//  4. duty=8 latched at wrap -> led high exactly 8 of every 16 clks, 1 clk after pwm_cnt 0..7.
//     A tick mid-period does not change led until the next wrap.
//  5. enable=0 at duty=8/UP, 3 ticks -> led=0 next clk, duty=8, phase=0 unchanged.
//     enable=1, 1 tick -> duty=12.
//  6. rst pulsed for 1 clk during DOWN with duty=7 -> next clk led=0, duty=0, phase=0, hold_cnt=0.

Source files
------------

// File: rtl/led_breathe_pkg.sv
// Shared definitions for the breathing-LED sequencer: phase encodings and widths.
package led_breathe_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_UP      = 2'd0,
    PH_HOLD_HI = 2'd1,
    PH_DOWN    = 2'd2,
    PH_HOLD_LO = 2'd3
  } phase_e;

endpackage

// File: rtl/led_breathe_if.sv
// Bundle of the divider input, enable and LED/status outputs of the breathing-LED block.
interface led_breathe_if
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS = 8
) ();

  logic                tick_in;
  logic                enable;
  logic                led;
  logic [PWM_BITS-1:0] duty;
  phase_e              phase;

  modport master (
    output tick_in,
    output enable,
    input  led,
    input  duty,
    input  phase
  );

  modport slave (
    input  tick_in,
    input  enable,
    output led,
    output duty,
    output phase
  );

endinterface

// File: rtl/tick_edge.sv
// Rising-edge detector turning a slow level into a single-cycle pulse.
module tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  logic level_prev_reg;

  // Reset also tracks the level, so a level already high at release gives no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_reg <= level_in;
    end else begin
      level_prev_reg <= level_in;
    end
  end

  assign pulse_out = level_in & ~level_prev_reg;

endmodule

// File: rtl/led_breathe.sv
// Breathing LED: divider ticks step an up/hold/down/hold duty sequencer driving a PWM output.
module led_breathe
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic         clk,
  input  logic         rst,
  led_breathe_if.slave bus
);

  localparam logic [PWM_BITS-1:0] MAXD      = '1;
  localparam logic [PWM_BITS:0]   MAXD_W    = {1'b0, MAXD};
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
  localparam int                  HOLD_W    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam phase_e AFTER_UP   = (HOLD_TICKS > 0) ? PH_HOLD_HI : PH_DOWN;
  localparam phase_e AFTER_DOWN = (HOLD_TICKS > 0) ? PH_HOLD_LO : PH_UP;

  logic                tick;
  logic                advance;
  phase_e              phase_reg, phase_next;
  logic [PWM_BITS-1:0] duty_reg, duty_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PWM_BITS-1:0] duty_act_reg;
  logic                led_reg;
  logic [PWM_BITS:0]   duty_up;

  tick_edge u_tick_edge (
    .clk       (clk),
    .rst       (rst),
    .level_in  (bus.tick_in),
    .pulse_out (tick)
  );

  assign advance = tick & bus.enable;
  // One extra bit so the ramp saturates instead of wrapping past MAXD.
  assign duty_up = {1'b0, duty_reg} + STEP_W;

  always_comb begin
    phase_next    = phase_reg;
    duty_next     = duty_reg;
    hold_cnt_next = hold_cnt_reg;
    if (advance) begin
      case (phase_reg)
        PH_UP: begin
          if (duty_up >= MAXD_W) begin
            duty_next  = MAXD;
            phase_next = AFTER_UP;
          end else begin
            duty_next = duty_up[PWM_BITS-1:0];
          end
        end
        PH_HOLD_HI, PH_HOLD_LO: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            phase_next    = (phase_reg == PH_HOLD_HI) ? PH_DOWN : PH_UP;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
        PH_DOWN: begin
          if ({1'b0, duty_reg} <= STEP_W) begin
            duty_next  = '0;
            phase_next = AFTER_DOWN;
          end else begin
            duty_next = duty_reg - STEP_W[PWM_BITS-1:0];
          end
        end
        default: begin
          phase_next = PH_UP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg    <= PH_UP;
      duty_reg     <= '0;
      hold_cnt_reg <= '0;
    end else begin
      phase_reg    <= phase_next;
      duty_reg     <= duty_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // PWM runs regardless of enable; the duty is only sampled at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg  <= '0;
      duty_act_reg <= '0;
      led_reg      <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      if (pwm_cnt_reg == MAXD) begin
        duty_act_reg <= duty_reg;
      end
      led_reg <= bus.enable & (pwm_cnt_reg < duty_act_reg);
    end
  end

  assign bus.led   = led_reg;
  assign bus.duty  = duty_reg;
  assign bus.phase = phase_reg;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PWM_BITS=4, STEP=4, HOLD_TICKS=2.
module tb_led_breathe;
  import led_breathe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] m_pwm;

  led_breathe_if #(.PWM_BITS(4)) bus ();

  led_breathe #(
    .PWM_BITS   (4),
    .STEP       (4),
    .HOLD_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference PWM position: cleared by reset, +1 per clock.
  always @(posedge clk) begin
    if (rst) m_pwm <= 4'd0;
    else     m_pwm <= m_pwm + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One rising edge on tick_in, high for w cycles, then low for two cycles.
  task automatic pulse(input int w);
    bus.tick_in = 1'b1;
    repeat (w) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pwm(input logic [3:0] target);
    int n = 0;
    while (m_pwm != target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_pwm", {28'd0, m_pwm}, {28'd0, target});
  endtask

  // Checks led over n cycles: high exactly when the previous pwm position is
  // below the active duty (lim_a for the first `split` cycles, lim_b after).
  task automatic pwm_window(input string tag, input int n, input int split,
                            input int lim_a, input int lim_b, input int tick_at);
    int bad = 0;
    int highs = 0;
    for (int i = 0; i < n; i++) begin
      int p;
      int lim;
      logic exp_led;
      @(negedge clk);
      p = i % 16;
      lim = (i < split) ? lim_a : lim_b;
      exp_led = (p >= 1) && (p <= lim);
      if (bus.led !== exp_led) bad++;
      if (bus.led === 1'b1 && i < 16) highs++;
      if (i == tick_at) bus.tick_in = 1'b1;
      if (i == tick_at + 3) bus.tick_in = 1'b0;
    end
    check({tag, "_mismatches"}, bad, 0);
    check({tag, "_highs_first_period"}, highs, lim_a);
  endtask

  initial begin
    rst         = 1'b1;
    bus.tick_in = 1'b1;
    bus.enable  = 1'b1;

    // 1: tick_in high across reset release gives no tick
    repeat (3) @(negedge clk);
    check("rst_led", bus.led, 0);
    check("rst_duty", bus.duty, 0);
    check("rst_phase", bus.phase, PH_UP);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_duty", bus.duty, 0);
    check("rel_phase", bus.phase, PH_UP);
    check("rel_led", bus.led, 0);
    bus.tick_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_duty_after_fall", bus.duty, 0);

    // 2: ramp up with saturation; a wide pulse is one tick
    pulse(1);  check("up_duty4", bus.duty, 4);
    pulse(1);  check("up_duty8", bus.duty, 8);
    pulse(20); check("up_wide_duty12", bus.duty, 12);
    pulse(1);  check("up_sat_duty15", bus.duty, 15);
    check("up_to_hold_hi", bus.phase, PH_HOLD_HI);

    // 3: hold, ramp down, hold, back to up
    pulse(1);  check("hold_hi_1", bus.phase, PH_HOLD_HI);
    pulse(1);  check("hold_hi_exit", bus.phase, PH_DOWN);
    pulse(1);  check("down_duty11", bus.duty, 11);
    pulse(1);  check("down_duty7", bus.duty, 7);
    pulse(1);  check("down_duty3", bus.duty, 3);
    pulse(1);  check("down_duty0", bus.duty, 0);
    check("down_to_hold_lo", bus.phase, PH_HOLD_LO);
    pulse(1);  check("hold_lo_1", bus.phase, PH_HOLD_LO);
    pulse(1);  check("hold_lo_exit", bus.phase, PH_UP);
    pulse(1);  check("reup_duty4", bus.duty, 4);

    // 4a: duty 8 -> led high 8 of 16, one clock after pwm 0..7
    pulse(1);  check("pwm_duty8", bus.duty, 8);
    wait_pwm(4'd15);
    pwm_window("pwm8", 16, 16, 8, 8, 1000);

    // 5: enable low freezes sequencer and forces led low
    wait_pwm(4'd3);
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_led_next", bus.led, 0);
    pulse(1); pulse(1); pulse(1);
    check("dis_duty", bus.duty, 8);
    check("dis_phase", bus.phase, PH_UP);
    check("dis_led", bus.led, 0);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    pulse(1);  check("en_duty12", bus.duty, 12);

    // 4b: tick mid-period only takes effect at the following wrap
    wait_pwm(4'd15);
    pwm_window("pwm12", 48, 32, 12, 15, 18);
    check("mid_duty15", bus.duty, 15);
    check("mid_phase", bus.phase, PH_HOLD_HI);

    // 6: reset during DOWN with duty 7
    pulse(1); pulse(1);
    pulse(1);  check("d_duty11", bus.duty, 11);
    pulse(1);  check("d_duty7", bus.duty, 7);
    check("d_phase", bus.phase, PH_DOWN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_led", bus.led, 0);
    check("mid_rst_duty", bus.duty, 0);
    check("mid_rst_phase", bus.phase, PH_UP);
    check("mid_rst_hold", dut.hold_cnt_reg, 0);
    pulse(1);  check("post_rst_duty4", bus.duty, 4);

    // Reset in HOLD_HI with hold progress pending discards it
    pulse(1); pulse(1); pulse(1);
    check("h_duty15", bus.duty, 15);
    pulse(1);  check("h_hold1", dut.hold_cnt_reg, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("h_rst_hold", dut.hold_cnt_reg, 0);
    check("h_rst_phase", bus.phase, PH_UP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
